// File: rtl/fwd_scoreboard.sv
// Operand forwarding network plus long-latency scoreboard.
// Each read port resolves its operand from the youngest matching pipeline
// stage, then a same-cycle long-latency writeback, then the register file.
// The scoreboard tracks registers owed by mul/div and raises stall on
// read-after-write and write-after-write hazards.

// Per read port: priority mux over stages / long writeback / regfile.
module fwd_port #(
   parameter int NSTAGE = 3,
   parameter int AW     = 5,
   parameter int DW     = 64,
   parameter int NREG   = 32
) (
   input  logic [AW-1:0]                 rd_addr,
   input  logic [DW-1:0]                 rd_data,
   input  logic [NSTAGE-1:0]             stg_valid,
   input  logic [NSTAGE-1:0][AW-1:0]     stg_wa,
   input  logic [NSTAGE-1:0][DW-1:0]     stg_wd,
   input  logic [NSTAGE-1:0]             stg_ready,
   input  logic                          lc_done,
   input  logic [AW-1:0]                 lc_wa,
   input  logic [DW-1:0]                 lc_wd,
   input  logic [NREG-1:0]               sb_busy,
   output logic [DW-1:0]                 fwd_data,
   output logic                          hazard
);

   logic          hit;
   logic          hit_rdy;
   logic [DW-1:0] hit_wd;
   logic          lc_hit;

   // Scan oldest to youngest so the youngest matching stage is the last writer.
   always_comb begin
      hit     = 1'b0;
      hit_rdy = 1'b0;
      hit_wd  = '0;
      for (int i = NSTAGE-1; i >= 0; i--) begin
         if (stg_valid[i] && (stg_wa[i] == rd_addr)) begin
            hit     = 1'b1;
            hit_rdy = stg_ready[i];
            hit_wd  = stg_wd[i];
         end
      end
   end

   assign lc_hit = lc_done && (lc_wa == rd_addr);

   // x0 reads as zero and never waits; a not-yet-ready stage or an
   // outstanding long op with no writeback this cycle is a hazard.
   always_comb begin
      fwd_data = rd_data;
      hazard   = 1'b0;
      if (rd_addr == '0) begin
         fwd_data = '0;
      end else if (hit) begin
         fwd_data = hit_wd;
         hazard   = !hit_rdy;
      end else if (lc_hit) begin
         fwd_data = lc_wd;
      end else begin
         hazard   = sb_busy[rd_addr];
      end
   end

endmodule

// Top: port array, scoreboard state and stall counter.
module fwd_scoreboard #(
   parameter int NREAD  = 2,
   parameter int NSTAGE = 3,
   parameter int AW     = 5,
   parameter int DW     = 64
) (
   input  logic                   clk,
   input  logic                   resetn,
   input  logic [NREAD*AW-1:0]    rd_addr,
   input  logic [NREAD*DW-1:0]    rd_data,
   input  logic [NSTAGE-1:0]      stg_valid,
   input  logic [NSTAGE*AW-1:0]   stg_wa,
   input  logic [NSTAGE*DW-1:0]   stg_wd,
   input  logic [NSTAGE-1:0]      stg_ready,
   input  logic                   issue_valid,
   input  logic                   issue_long,
   input  logic [AW-1:0]          issue_wa,
   input  logic                   lc_done,
   input  logic [AW-1:0]          lc_wa,
   input  logic [DW-1:0]          lc_wd,
   output logic [NREAD*DW-1:0]    fwd_data,
   output logic                   stall,
   output logic [(2**AW)-1:0]     sb_busy,
   output logic [31:0]            stall_cnt
);

   localparam int NREG = 2**AW;

   logic [NREAD-1:0][AW-1:0]  ra;
   logic [NREAD-1:0][DW-1:0]  rdat;
   logic [NREAD-1:0][DW-1:0]  fd;
   logic [NREAD-1:0]          haz;
   logic [NSTAGE-1:0][AW-1:0] swa;
   logic [NSTAGE-1:0][DW-1:0] swd;

   logic [NREG-1:0] sb_q, sb_d;
   logic [31:0]     cnt_q;
   logic            waw;
   logic            issue_acc;

   assign ra       = rd_addr;
   assign rdat     = rd_data;
   assign swa      = stg_wa;
   assign swd      = stg_wd;
   assign fwd_data = fd;

   genvar p;
   generate
      for (p = 0; p < NREAD; p++) begin : g_port
         fwd_port #(.NSTAGE(NSTAGE), .AW(AW), .DW(DW), .NREG(NREG)) u_port (
            .rd_addr   (ra[p]),
            .rd_data   (rdat[p]),
            .stg_valid (stg_valid),
            .stg_wa    (swa),
            .stg_wd    (swd),
            .stg_ready (stg_ready),
            .lc_done   (lc_done),
            .lc_wa     (lc_wa),
            .lc_wd     (lc_wd),
            .sb_busy   (sb_q),
            .fwd_data  (fd[p]),
            .hazard    (haz[p])
         );
      end
   endgenerate

   // A second long op to a still-owed register must wait, unless the
   // owed result retires this very cycle.
   assign waw = issue_valid && issue_long && (issue_wa != '0) && sb_q[issue_wa]
                && !(lc_done && (lc_wa == issue_wa));

   assign stall     = (|haz) || waw;
   assign issue_acc = issue_valid && issue_long && !stall && (issue_wa != '0);
   assign sb_busy   = sb_q;
   assign stall_cnt = cnt_q;

   // Next scoreboard: clear on writeback, then set on accepted issue so a
   // same-edge set/clear on one register leaves it busy; x0 never busy.
   always_comb begin
      sb_d = sb_q;
      if (lc_done)   sb_d[lc_wa]    = 1'b0;
      if (issue_acc) sb_d[issue_wa] = 1'b1;
      sb_d[0] = 1'b0;
   end

   // Scoreboard and saturating stall counter registers.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         sb_q  <= '0;
         cnt_q <= '0;
      end else begin
         sb_q <= sb_d;
         if (stall && (cnt_q != 32'hFFFF_FFFF)) cnt_q <= cnt_q + 32'd1;
      end
   end

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Directed bench for fwd_scoreboard: combinational forwarding table plus
// hand-written scoreboard, reset and counter sequences.
module tb_fwd_scoreboard;

   logic         clk;
   logic         resetn;
   logic [9:0]   rd_addr;
   logic [127:0] rd_data;
   logic [2:0]   stg_valid;
   logic [14:0]  stg_wa;
   logic [191:0] stg_wd;
   logic [2:0]   stg_ready;
   logic         issue_valid;
   logic         issue_long;
   logic [4:0]   issue_wa;
   logic         lc_done;
   logic [4:0]   lc_wa;
   logic [63:0]  lc_wd;
   logic [127:0] fwd_data;
   logic         stall;
   logic [31:0]  sb_busy;
   logic [31:0]  stall_cnt;

   int nchk = 0;
   int nerr = 0;

   fwd_scoreboard dut (
      .clk(clk), .resetn(resetn), .rd_addr(rd_addr), .rd_data(rd_data),
      .stg_valid(stg_valid), .stg_wa(stg_wa), .stg_wd(stg_wd),
      .stg_ready(stg_ready), .issue_valid(issue_valid), .issue_long(issue_long),
      .issue_wa(issue_wa), .lc_done(lc_done), .lc_wa(lc_wa), .lc_wd(lc_wd),
      .fwd_data(fwd_data), .stall(stall), .sb_busy(sb_busy), .stall_cnt(stall_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [4:0]  a0, a1;
      logic [63:0] d0, d1;
      logic [2:0]  sv, sr;
      logic [4:0]  w0, w1, w2;
      logic [63:0] x0, x1, x2;
      logic        lcd;
      logic [4:0]  lca;
      logic [63:0] lcw;
      logic [63:0] e0, e1;
      logic        m0, m1;
      logic        es;
   } vec_t;

   vec_t tv[8];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   task automatic clr();
      rd_addr = '0; rd_data = '0; stg_valid = '0; stg_wa = '0; stg_wd = '0;
      stg_ready = '0; issue_valid = 0; issue_long = 0; issue_wa = '0;
      lc_done = 0; lc_wa = '0; lc_wd = '0;
   endtask

   task automatic long_issue(input logic [4:0] wa);
      @(negedge clk);
      clr();
      issue_valid = 1; issue_long = 1; issue_wa = wa;
      @(posedge clk);
      @(negedge clk);
      clr();
   endtask

   initial begin
      //         a0 a1 d0       d1      sv    sr     w0  w1  w2  x0       x1      x2      lcd lca lcw       e0       e1      m0 m1 es
      tv[0] = '{5, 2, 64'h5,   64'h22, 3'b101, 3'b111, 5,  0,  5,  64'h11, 64'h0,  64'h33, 0, 0,  64'h0,    64'h11,  64'h22, 1, 1, 0};
      tv[1] = '{0, 3, 64'h55,  64'h3,  3'b001, 3'b000, 0,  0,  0,  64'h99, 64'h0,  64'h0,  0, 0,  64'h0,    64'h0,   64'h3,  1, 1, 0};
      tv[2] = '{8, 8, 64'h1,   64'h2,  3'b010, 3'b111, 0,  9,  0,  64'h0,  64'h9,  64'h0,  1, 8,  64'hABC,  64'hABC, 64'hABC,1, 1, 0};
      tv[3] = '{6, 6, 64'h1,   64'h2,  3'b010, 3'b010, 0,  6,  0,  64'h0,  64'h66, 64'h0,  1, 6,  64'h77,   64'h66,  64'h66, 1, 1, 0};
      tv[4] = '{1, 7, 64'h1,   64'h2,  3'b100, 3'b000, 0,  0,  7,  64'h0,  64'h0,  64'h70, 0, 0,  64'h0,    64'h1,   64'h0,  1, 0, 1};
      tv[5] = '{10,0, 64'h1,   64'h2,  3'b101, 3'b001, 10, 0,  10, 64'hA0, 64'h0,  64'hA2, 0, 0,  64'h0,    64'hA0,  64'h0,  1, 1, 0};
      tv[6] = '{11,0, 64'h1,   64'h2,  3'b011, 3'b010, 11, 11, 0,  64'hB0, 64'hB1, 64'h0,  0, 0,  64'h0,    64'h0,   64'h0,  0, 1, 1};
      tv[7] = '{12,12,64'hC0C0,64'hC0C0,3'b000,3'b111, 12, 12, 12, 64'h1,  64'h2,  64'h3,  0, 0,  64'h0,    64'hC0C0,64'hC0C0,1, 1, 0};

      clr();
      resetn = 0;
      #1;
      chk("rst sb_busy", 64'(sb_busy), 64'h0);
      chk("rst stall_cnt", 64'(stall_cnt), 64'h0);
      chk("rst stall", 64'(stall), 64'h0);
      @(negedge clk);
      resetn = 1;

      // Combinational forwarding table, empty scoreboard.
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         clr();
         rd_addr   = {tv[i].a1, tv[i].a0};
         rd_data   = {tv[i].d1, tv[i].d0};
         stg_valid = tv[i].sv;
         stg_ready = tv[i].sr;
         stg_wa    = {tv[i].w2, tv[i].w1, tv[i].w0};
         stg_wd    = {tv[i].x2, tv[i].x1, tv[i].x0};
         lc_done   = tv[i].lcd;
         lc_wa     = tv[i].lca;
         lc_wd     = tv[i].lcw;
         #1;
         if (tv[i].m0) chk($sformatf("vec%0d fwd0", i), fwd_data[63:0], tv[i].e0);
         if (tv[i].m1) chk($sformatf("vec%0d fwd1", i), fwd_data[127:64], tv[i].e1);
         chk($sformatf("vec%0d stall", i), 64'(stall), 64'(tv[i].es));
      end

      // Fresh reset so the counter starts from a known value.
      @(negedge clk);
      clr();
      resetn = 0;
      #1;
      chk("rst2 stall_cnt", 64'(stall_cnt), 64'h0);
      @(negedge clk);
      resetn = 1;

      // Not-ready stage stalls and counts; ready releases.
      @(negedge clk);
      clr();
      rd_addr[4:0] = 7; stg_valid = 3'b001; stg_wa[4:0] = 7; stg_ready = 3'b000;
      #1 chk("nr stall", 64'(stall), 64'h1);
      @(negedge clk);
      chk("nr cnt1", 64'(stall_cnt), 64'd1);
      @(negedge clk);
      chk("nr cnt2", 64'(stall_cnt), 64'd2);
      stg_ready = 3'b001;
      #1 chk("rdy stall", 64'(stall), 64'h0);
      @(negedge clk);
      chk("rdy cnt hold", 64'(stall_cnt), 64'd2);

      // Long op to x9: RAW stall, then same-cycle writeback forwards.
      @(negedge clk);
      clr();
      issue_valid = 1; issue_long = 1; issue_wa = 9;
      #1 chk("iss9 stall", 64'(stall), 64'h0);
      @(negedge clk);
      clr();
      rd_addr[4:0] = 9; rd_data[63:0] = 64'h1234;
      #1;
      chk("x9 stall", 64'(stall), 64'h1);
      chk("x9 busy", 64'(sb_busy[9]), 64'h1);
      lc_done = 1; lc_wa = 9; lc_wd = 64'hABCD;
      #1;
      chk("x9 lc fwd", fwd_data[63:0], 64'hABCD);
      chk("x9 lc stall", 64'(stall), 64'h0);
      @(negedge clk);
      lc_done = 0;
      #1;
      chk("x9 cleared", 64'(sb_busy), 64'h0);
      chk("x9 rf fwd", fwd_data[63:0], 64'h1234);
      chk("x9 cnt", 64'(stall_cnt), 64'd2);

      // WAW on x4, and same-edge set/clear leaves it busy.
      long_issue(4);
      chk("x4 busy", 64'(sb_busy), 64'h10);
      issue_valid = 1; issue_long = 1; issue_wa = 4;
      #1 chk("waw stall", 64'(stall), 64'h1);
      lc_done = 1; lc_wa = 4;
      #1 chk("waw lc stall", 64'(stall), 64'h0);
      @(negedge clk);
      clr();
      chk("x4 set wins", 64'(sb_busy), 64'h10);
      lc_done = 1; lc_wa = 4;
      @(negedge clk);
      clr();
      chk("x4 clear", 64'(sb_busy), 64'h0);
      lc_done = 1; lc_wa = 13;
      @(negedge clk);
      clr();
      chk("lc nonbusy", 64'(sb_busy), 64'h0);

      // x0 never forwards, stalls or becomes busy.
      rd_addr[4:0] = 0; stg_valid = 3'b001; stg_wa[4:0] = 0; stg_wd[63:0] = 64'hFF;
      issue_valid = 1; issue_long = 1; issue_wa = 0;
      #1;
      chk("x0 fwd", fwd_data[63:0], 64'h0);
      chk("x0 stall", 64'(stall), 64'h0);
      @(negedge clk);
      clr();
      chk("x0 busy", 64'(sb_busy), 64'h0);

      // Asynchronous reset mid-cycle forgets outstanding ops.
      long_issue(3);
      long_issue(12);
      chk("x3x12 busy", 64'(sb_busy), 64'h1008);
      rd_addr[4:0] = 3; rd_data[63:0] = 64'h3333;
      #1 chk("x3 stall", 64'(stall), 64'h1);
      #1 resetn = 0;
      #1;
      chk("arst busy", 64'(sb_busy), 64'h0);
      chk("arst cnt", 64'(stall_cnt), 64'h0);
      chk("arst stall", 64'(stall), 64'h0);
      chk("arst fwd", fwd_data[63:0], 64'h3333);
      @(negedge clk);
      resetn = 1;
      clr();
      lc_done = 1; lc_wa = 3;
      @(negedge clk);
      clr();
      chk("late lc", 64'(sb_busy), 64'h0);

      // Counter saturation.
      force dut.cnt_q = 32'hFFFF_FFFD;
      #1 release dut.cnt_q;
      rd_addr[4:0] = 7; stg_valid = 3'b001; stg_wa[4:0] = 7; stg_ready = 3'b000;
      @(negedge clk);
      chk("sat fffe", 64'(stall_cnt), 64'hFFFF_FFFE);
      @(negedge clk);
      chk("sat ffff", 64'(stall_cnt), 64'hFFFF_FFFF);
      @(negedge clk);
      chk("sat hold", 64'(stall_cnt), 64'hFFFF_FFFF);
      clr();

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
